// File: rtl/hbram_pkg.sv
// Shared encodings and helpers for the HyperRAM burst arbiter.
// Includes the FSM state codes and the windowed address-increment function.
package hbram_pkg;

   localparam logic [2:0] ST_CAL     = 3'd0;
   localparam logic [2:0] ST_ARB     = 3'd1;
   localparam logic [2:0] ST_REQ     = 3'd2;
   localparam logic [2:0] ST_WAIT_OP = 3'd3;
   localparam logic [2:0] ST_BUSY    = 3'd4;
   localparam logic [2:0] ST_UPD     = 3'd5;

   function automatic int slot_w(input int num_ch);
      return $clog2(2 * num_ch);
   endfunction

   // The 33-bit sum keeps a pointer near 2^32 from wrapping past max.
   // When min >= max, every step lands back on min.
   function automatic logic [31:0] addr_next(input logic [31:0] ptr,
                                             input logic [31:0] min,
                                             input logic [31:0] max,
                                             input logic [31:0] inc);
      logic [32:0] nxt;
      nxt = {1'b0, ptr} + {1'b0, inc};
      if (nxt >= {1'b0, max})
         return min;
      return nxt[31:0];
   endfunction

endpackage

// File: rtl/hbram_rr_arb.sv
// Combinational round-robin picker.
// Returns the first requesting slot at or after rr_ptr, wrapping around.
module hbram_rr_arb
   import hbram_pkg::*;
#(
   parameter int NUM_SLOTS = 4,
   parameter int SLOT_W    = 2
) (
   input  logic [NUM_SLOTS-1:0] req,
   input  logic [SLOT_W-1:0]    rr_ptr,
   output logic                 hit,
   output logic [SLOT_W-1:0]    slot
);

   // Walk offsets from farthest to nearest so the closest requester wins last.
   always_comb begin
      hit  = 1'b0;
      slot = '0;
      for (int k = NUM_SLOTS - 1; k >= 0; k--) begin
         int idx;
         idx = (int'(rr_ptr) + k) % NUM_SLOTS;
         if (req[idx]) begin
            hit  = 1'b1;
            slot = idx[SLOT_W-1:0];
         end
      end
   end

endmodule

// File: rtl/hbram_burst_arbiter.sv
// Round-robin burst scheduler sharing one HyperRAM controller between channels.
// Each channel has a write path and a read path with its own address window.
module hbram_burst_arbiter
   import hbram_pkg::*;
#(
   parameter int NUM_CH      = 2,
   parameter int BURST_BYTES = 64,
   parameter int TIMEOUT     = 1023
) (
   input  logic                 ram_clock,
   input  logic                 ram_reset,
   input  logic                 hbc_cal_pass,
   input  logic [NUM_CH-1:0]    wr_req,
   input  logic [NUM_CH-1:0]    rd_req,
   input  logic [NUM_CH-1:0]    addr_rst,
   input  logic [32*NUM_CH-1:0] wr_addr_min,
   input  logic [32*NUM_CH-1:0] wr_addr_max,
   input  logic [32*NUM_CH-1:0] rd_addr_min,
   input  logic [32*NUM_CH-1:0] rd_addr_max,
   input  logic                 operating,
   output logic                 ram_en,
   output logic                 ram_rw_ctrl,
   output logic [31:0]          ram_addr,
   output logic [NUM_CH-1:0]    wr_grant,
   output logic [NUM_CH-1:0]    rd_grant,
   output logic                 ctrl_idle,
   output logic                 timeout_err
);

   localparam int NUM_SLOTS = 2 * NUM_CH;
   localparam int SLOT_W    = slot_w(NUM_CH);
   localparam int TMR_W     = $clog2(TIMEOUT + 1);

   logic [2:0]                  state, state_nxt;
   logic                        op_q, op_rise, op_fall;
   logic [SLOT_W-1:0]           rr_ptr, slot_q, arb_slot;
   logic                        arb_hit, timed_out;
   logic [TMR_W-1:0]            timer;
   logic                        gnt_vld, gnt_rw;
   logic [31:0]                 gnt_addr, sel_addr;
   logic [NUM_CH-1:0][31:0]     wr_ptr, rd_ptr;

   assign op_rise   = operating & ~op_q;
   assign op_fall   = ~operating & op_q;
   assign timed_out = (state == ST_WAIT_OP) && !op_rise && (timer == TMR_W'(TIMEOUT - 1));

   hbram_rr_arb #(.NUM_SLOTS(NUM_SLOTS), .SLOT_W(SLOT_W)) u_rr_arb (
      .req    ({rd_req, wr_req}),
      .rr_ptr (rr_ptr),
      .hit    (arb_hit),
      .slot   (arb_slot)
   );

   always_comb begin
      sel_addr = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (arb_slot == SLOT_W'(i))          sel_addr = wr_ptr[i];
         if (arb_slot == SLOT_W'(i + NUM_CH)) sel_addr = rd_ptr[i];
      end
   end

   always_ff @(posedge ram_clock) begin
      if (ram_reset) state <= ST_CAL;
      else           state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_CAL:     if (hbc_cal_pass) state_nxt = ST_ARB;
         ST_ARB:     if (arb_hit)      state_nxt = ST_REQ;
         ST_REQ:                       state_nxt = ST_WAIT_OP;
         ST_WAIT_OP: if (op_rise)      state_nxt = ST_BUSY;
                     else if (timed_out) state_nxt = ST_ARB;
         ST_BUSY:    if (op_fall)      state_nxt = ST_UPD;
         ST_UPD:                       state_nxt = ST_ARB;
         default:                      state_nxt = ST_CAL;
      endcase
   end

   always_comb begin
      ram_en      = (state == ST_REQ);
      ctrl_idle   = (state == ST_CAL) || (state == ST_ARB);
      ram_rw_ctrl = gnt_rw;
      ram_addr    = gnt_addr;
      for (int i = 0; i < NUM_CH; i++) begin
         wr_grant[i] = gnt_vld && !gnt_rw && (slot_q == SLOT_W'(i));
         rd_grant[i] = gnt_vld &&  gnt_rw && (slot_q == SLOT_W'(i + NUM_CH));
      end
   end

   // Grant registers, timer, rr pointer and sticky timeout flag.
   always_ff @(posedge ram_clock) begin
      if (ram_reset) begin
         op_q        <= 1'b0;
         rr_ptr      <= '0;
         slot_q      <= '0;
         gnt_vld     <= 1'b0;
         gnt_rw      <= 1'b1;
         gnt_addr    <= '0;
         timer       <= '0;
         timeout_err <= 1'b0;
      end else begin
         op_q <= operating;
         case (state)
            ST_ARB: if (arb_hit) begin
               slot_q   <= arb_slot;
               gnt_vld  <= 1'b1;
               gnt_rw   <= (arb_slot >= SLOT_W'(NUM_CH));
               gnt_addr <= sel_addr;
            end
            ST_REQ: timer <= '0;
            ST_WAIT_OP: begin
               timer <= timer + 1'b1;
               if (timed_out) begin
                  timeout_err <= 1'b1;
                  gnt_vld     <= 1'b0;
                  gnt_rw      <= 1'b1;
                  gnt_addr    <= '0;
               end
            end
            ST_UPD: begin
               rr_ptr   <= (slot_q == SLOT_W'(NUM_SLOTS - 1)) ? '0 : slot_q + 1'b1;
               gnt_vld  <= 1'b0;
               gnt_rw   <= 1'b1;
               gnt_addr <= '0;
            end
            default: ;
         endcase
      end
   end

   // An addr_rst reload takes priority over the post-burst increment.
   always_ff @(posedge ram_clock) begin
      if (ram_reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (state == ST_CAL) begin
               if (hbc_cal_pass) begin
                  wr_ptr[i] <= wr_addr_min[32*i +: 32];
                  rd_ptr[i] <= rd_addr_min[32*i +: 32];
               end
            end else if (addr_rst[i]) begin
               wr_ptr[i] <= wr_addr_min[32*i +: 32];
               rd_ptr[i] <= rd_addr_min[32*i +: 32];
            end else if (state == ST_UPD) begin
               if (slot_q == SLOT_W'(i))
                  wr_ptr[i] <= addr_next(wr_ptr[i], wr_addr_min[32*i +: 32],
                                         wr_addr_max[32*i +: 32], 32'(BURST_BYTES));
               if (slot_q == SLOT_W'(i + NUM_CH))
                  rd_ptr[i] <= addr_next(rd_ptr[i], rd_addr_min[32*i +: 32],
                                         rd_addr_max[32*i +: 32], 32'(BURST_BYTES));
            end
         end
      end
   end

endmodule
